rename_retire_core: RTL and testbench
=====================================

// Module: rename_retire_core
// PURPOSE
// - R10K-style rename/retire core: merges the map table, free list and ROB behind one dispatch/complete/retire interface.
// - Sits between decode (stage_id) and the reservation stations.
// - Renames one instruction per cycle, tracks tag readiness from the CDB, retires in order, recycles Told.
// PARAMETERS
// N_ARCH   32  architectural registers; r0 is never renamed
// N_PHYS   64  physical registers; tag width = $clog2(N_PHYS) = 6
// ROB_SZ   32  ROB entries; index width 5
// PORTS
// clock          in   1  rising-edge clock
// reset          in   1  asynchronous, active-high
// cdb_en         in   1  CDB broadcast valid this cycle
// cdb_tag        in   6  physical tag being broadcast
// disp_valid     in   1  decode presents an instruction
// disp_has_dest  in   1  instruction writes a register
// disp_dest      in   5  architectural destination
// disp_src1      in   5  architectural source 1
// disp_src2      in   5  architectural source 2
// disp_stall     out  1  dispatch refused this cycle
// disp_t         out  6  newly allocated tag T
// disp_told      out  6  previous mapping of dest (Told)
// disp_t1        out  6  tag of src1
// disp_t1_rdy    out  1  src1 ready
// disp_t2        out  6  tag of src2
// disp_t2_rdy    out  1  src2 ready
// disp_rob_idx   out  5  ROB slot assigned
// cmpl_en        in   1  execution complete
// cmpl_idx       in   5  ROB slot completing
// ret_en         out  1  head instruction retires this cycle
// ret_dest       out  5  retiring architectural register
// ret_t          out  6  retiring T
// ret_told       out  6  Told returned to free list
// BEHAVIOUR
// - Reset (async): map[r] = {tag r, ready 1}; free list holds 32..63 in order, head = 32; ROB empty; ret_en = 0.
// - Dest r0 is treated as has_dest = 0. Source r0 yields tag 0, ready 1.
// - disp_stall = disp_valid & (rob_full | (has_dest & fl_empty)).
// - fire = disp_valid & ~disp_stall.
// - All disp_* outputs are combinational from current state.
//   - disp_t = FL head; disp_told = map[dest].tag; disp_rob_idx = ROB tail.
//   - disp_tX_rdy = map[srcX].ready | (cdb_en & cdb_tag == map[srcX].tag), i.e. same-cycle CDB forward.
// - Outputs are don't-care when not fired. disp_t and disp_told are 0 when has_dest = 0.
// - On each edge with fire:
//   - map[dest] <= {T, ready 0}; FL head++.
//   - ROB[tail] <= {dest, T, Told, has_dest, done 0}; tail++ (mod ROB_SZ); count++.
// - CDB: at each edge with cdb_en, every map entry whose tag == cdb_tag sets ready = 1.
//   - A same-cycle dispatch write to that arch reg wins (new tag, ready 0).
// - Complete: at the edge, cmpl_en sets ROB[cmpl_idx].done. Completing an empty slot is ignored.
// - Retire: ret_en = (count != 0) & ROB[head].done, combinational.
//   - At the edge: head++, count--; if has_dest, push Told to the FL tail.
// - Simultaneous dispatch and retire are allowed. Full/empty use registered counts.
//   - No same-cycle bypass of a freed tag to dispatch.
// - Wrap-around: all ROB and FL pointers are modulo their depth. FL depth = N_PHYS - N_ARCH = 32.
// - Reset mid-operation discards all in-flight state immediately. No branch recovery in this block.
// STRUCTURE
// - Shared package: N_ARCH, N_PHYS, ROB_SZ, tag width, TAG typedef {phys_reg, ready, valid}, ROB entry struct.
// - One sub-module: rename_tag_fifo (free-list circular FIFO with push/pop and empty/full).
// TESTING
// - Reset -> src r6 gives t1 = 6, rdy 1; disp_t = 32; disp_rob_idx = 0; ret_en = 0.
// - addi r6 <- r6 + 5, then addi r7 <- r7 + 5 -> T = 32/Told = 6, then T = 33/Told = 7; rob_idx 0, 1.
// - mult r15 <- r6 * r7 with cdb_en, tag 33 in the same cycle -> t1 = 32 rdy 0, t2 = 33 rdy 1 (forward); T = 34.
// - Next cycle cdb tag 32 -> after the edge map[r6].ready = 1. cmpl_en idx 0 -> ret_en with ret_told = 6.
//   - After 6 is pushed, 6 is allocated after 63.
// - 32 dispatches with no retire -> disp_stall = 1; one retire then frees a slot and dispatch resumes next cycle.
// - Assert reset with entries in flight -> ROB empty and identity map immediately; disp_t = 32 again.

Source files
------------

// File: rtl/rename_retire_core_pkg.sv
// Shared types and sizes for the rename/retire core: map-table tags,
// ROB entries and the pointer widths derived from the table depths.
package rename_retire_core_pkg;

    localparam int N_ARCH   = 32;
    localparam int N_PHYS   = 64;
    localparam int ROB_SZ   = 32;
    localparam int TAG_W    = $clog2(N_PHYS);
    localparam int ARCH_W   = $clog2(N_ARCH);
    localparam int ROB_W    = $clog2(ROB_SZ);
    localparam int FL_DEPTH = N_PHYS - N_ARCH;

    typedef logic [TAG_W-1:0]  phys_t;
    typedef logic [ARCH_W-1:0] arch_t;
    typedef logic [ROB_W-1:0]  rob_idx_t;

    // One map-table entry: current physical tag and whether its value exists.
    typedef struct packed {
        phys_t phys_reg;
        logic  ready;
        logic  valid;
    } tag_t;

    // One reorder-buffer slot.
    typedef struct packed {
        arch_t dest;
        phys_t t;
        phys_t told;
        logic  has_dest;
        logic  done;
    } rob_entry_t;

    // ROB_SZ is a power of two, so the natural wrap of the index is the modulo.
    function automatic rob_idx_t rob_next(input rob_idx_t i);
        return i + rob_idx_t'(1);
    endfunction

endpackage

// File: rtl/rename_retire_core_if.sv
// Dispatch / CDB / complete / retire bundle between decode, execution and
// the rename core. master drives instructions and events, slave is the core.
//
// Handshake: dispatch is a valid/stall pair. An instruction is accepted on a
// rising edge where disp_valid is high and disp_stall is low; every disp_*
// result is combinational and only meaningful in that same cycle. cdb_en,
// cmpl_en and ret_en are single-cycle strobes with no back-pressure.
interface rename_retire_core_if;
    import rename_retire_core_pkg::*;

    logic     cdb_en;
    phys_t    cdb_tag;
    logic     disp_valid;
    logic     disp_has_dest;
    arch_t    disp_dest;
    arch_t    disp_src1;
    arch_t    disp_src2;
    logic     disp_stall;
    phys_t    disp_t;
    phys_t    disp_told;
    phys_t    disp_t1;
    logic     disp_t1_rdy;
    phys_t    disp_t2;
    logic     disp_t2_rdy;
    rob_idx_t disp_rob_idx;
    logic     cmpl_en;
    rob_idx_t cmpl_idx;
    logic     ret_en;
    arch_t    ret_dest;
    phys_t    ret_t;
    phys_t    ret_told;

    modport master (
        output cdb_en, cdb_tag, disp_valid, disp_has_dest, disp_dest,
               disp_src1, disp_src2, cmpl_en, cmpl_idx,
        input  disp_stall, disp_t, disp_told, disp_t1, disp_t1_rdy,
               disp_t2, disp_t2_rdy, disp_rob_idx, ret_en, ret_dest,
               ret_t, ret_told
    );

    modport slave (
        input  cdb_en, cdb_tag, disp_valid, disp_has_dest, disp_dest,
               disp_src1, disp_src2, cmpl_en, cmpl_idx,
        output disp_stall, disp_t, disp_told, disp_t1, disp_t1_rdy,
               disp_t2, disp_t2_rdy, disp_rob_idx, ret_en, ret_dest,
               ret_t, ret_told
    );

endinterface

// File: rtl/rename_retire_core_tag_fifo.sv
// Free-list circular FIFO of physical tags. Comes out of reset full,
// holding BASE .. BASE+DEPTH-1 in order, head at BASE.
module rename_tag_fifo
    import rename_retire_core_pkg::*;
#(
    parameter int DEPTH = FL_DEPTH,
    parameter int BASE  = N_ARCH
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  push,
    input  phys_t push_tag,
    input  logic  pop,
    output phys_t head_tag,
    output logic  empty,
    output logic  full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] INIT_COUNT = (PW+1)'(DEPTH);

    phys_t         mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == INIT_COUNT);
    assign head_tag = mem[head];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // Storage: reset reloads the initial free tags, push writes at the tail.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= phys_t'(BASE + i);
            end
        end else if (do_push) begin
            mem[tail] <= push_tag;
        end
    end

    // Pointers and occupancy; both wrap at DEPTH (a power of two).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= INIT_COUNT;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rename_retire_core.sv
// R10K-style rename/retire core: map table, free list and ROB behind one
// dispatch / CDB / complete / retire interface. One rename per cycle,
// in-order retirement, Told recycled to the free list at retire.
module rename_retire_core
    import rename_retire_core_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    rename_retire_core_if.slave   bus
);

    tag_t        map_q [N_ARCH];
    rob_entry_t  rob_q [ROB_SZ];
    rob_idx_t    rob_head;
    rob_idx_t    rob_tail;
    logic [ROB_W:0] rob_count;

    phys_t    fl_head_tag;
    logic     fl_empty;
    logic     fl_full;
    logic     fl_push;

    logic     has_dest;
    logic     rob_full;
    logic     fire;
    logic     retire;
    logic     cmpl_hit;
    rob_idx_t cmpl_off;
    tag_t     src1_map;
    tag_t     src2_map;
    rob_entry_t head_entry;

    // Writing r0 is architecturally a no-op, so it never consumes a tag.
    assign has_dest  = bus.disp_has_dest & (bus.disp_dest != '0);
    assign rob_full  = (rob_count == (ROB_W+1)'(ROB_SZ));
    assign fire      = bus.disp_valid & ~bus.disp_stall;
    assign head_entry = rob_q[rob_head];
    assign retire    = (rob_count != '0) & head_entry.done;
    assign fl_push   = retire & head_entry.has_dest;

    // A completion only counts if its slot lies in [head, head+count).
    assign cmpl_off  = bus.cmpl_idx - rob_head;
    assign cmpl_hit  = bus.cmpl_en & ({1'b0, cmpl_off} < rob_count);

    // Dispatch results: lookups from current state plus same-cycle CDB forward.
    always_comb begin
        src1_map = map_q[bus.disp_src1];
        src2_map = map_q[bus.disp_src2];
        bus.disp_stall   = bus.disp_valid & (rob_full | (has_dest & fl_empty));
        bus.disp_t       = has_dest ? fl_head_tag : '0;
        bus.disp_told    = has_dest ? map_q[bus.disp_dest].phys_reg : '0;
        bus.disp_rob_idx = rob_tail;
        bus.disp_t1      = src1_map.phys_reg;
        bus.disp_t1_rdy  = src1_map.ready |
                           (bus.cdb_en & (bus.cdb_tag == src1_map.phys_reg));
        bus.disp_t2      = src2_map.phys_reg;
        bus.disp_t2_rdy  = src2_map.ready |
                           (bus.cdb_en & (bus.cdb_tag == src2_map.phys_reg));
        if (bus.disp_src1 == '0) begin
            bus.disp_t1     = '0;
            bus.disp_t1_rdy = 1'b1;
        end
        if (bus.disp_src2 == '0) begin
            bus.disp_t2     = '0;
            bus.disp_t2_rdy = 1'b1;
        end
    end

    assign bus.ret_en   = retire;
    assign bus.ret_dest = head_entry.dest;
    assign bus.ret_t    = head_entry.t;
    assign bus.ret_told = head_entry.told;

    rename_tag_fifo #(
        .DEPTH (FL_DEPTH),
        .BASE  (N_ARCH)
    ) u_free_list (
        .clock    (clock),
        .reset    (reset),
        .push     (fl_push),
        .push_tag (head_entry.told),
        .pop      (fire & has_dest),
        .head_tag (fl_head_tag),
        .empty    (fl_empty),
        .full     (fl_full)
    );

    // Map table: CDB marks matching tags ready; a same-cycle rename of the
    // same register is written last so the new tag (not ready) wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N_ARCH; r++) begin
                map_q[r] <= '{phys_reg: phys_t'(r), ready: 1'b1, valid: 1'b1};
            end
        end else begin
            if (bus.cdb_en) begin
                for (int r = 0; r < N_ARCH; r++) begin
                    if (map_q[r].phys_reg == bus.cdb_tag) map_q[r].ready <= 1'b1;
                end
            end
            if (fire && has_dest) begin
                map_q[bus.disp_dest] <= '{phys_reg: fl_head_tag, ready: 1'b0, valid: 1'b1};
            end
        end
    end

    // ROB storage: allocate at the tail on dispatch, mark done on completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROB_SZ; i++) begin
                rob_q[i] <= '0;
            end
        end else begin
            if (fire) begin
                rob_q[rob_tail] <= '{dest: bus.disp_dest, t: bus.disp_t,
                                     told: bus.disp_told, has_dest: has_dest,
                                     done: 1'b0};
            end
            if (cmpl_hit) rob_q[bus.cmpl_idx].done <= 1'b1;
        end
    end

    // ROB pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rob_head  <= '0;
            rob_tail  <= '0;
            rob_count <= '0;
        end else begin
            if (fire)   rob_tail <= rob_next(rob_tail);
            if (retire) rob_head <= rob_next(rob_head);
            case ({fire, retire})
                2'b10:   rob_count <= rob_count + 1'b1;
                2'b01:   rob_count <= rob_count - 1'b1;
                default: rob_count <= rob_count;
            endcase
        end
    end

endmodule

// File: tb/tb_rename_retire_core.sv
// Directed bench for rename_retire_core: rename sequence, CDB forwarding,
// completion/retire, free-list wrap, ROB-full stall and mid-run reset.
module tb_rename_retire_core;
    import rename_retire_core_pkg::*;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    rename_retire_core_if bus ();

    rename_retire_core dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    // Drive one cycle of inputs, then let combinational outputs settle.
    task automatic drive(input logic v, input logic hd, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic ce, input logic [5:0] ct,
                         input logic me, input logic [4:0] mi);
        bus.disp_valid    = v;
        bus.disp_has_dest = hd;
        bus.disp_dest     = d;
        bus.disp_src1     = s1;
        bus.disp_src2     = s2;
        bus.cdb_en        = ce;
        bus.cdb_tag       = ct;
        bus.cmpl_en       = me;
        bus.cmpl_idx      = mi;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // addi r6 <- r6 + 5 straight out of reset
        drive(1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 6'd0, 1'b0, 5'd0);
        check("rst_t1",     32'(bus.disp_t1), 32'd6);
        check("rst_t1_rdy", 32'(bus.disp_t1_rdy), 32'd1);
        check("rst_t2_r0",  32'(bus.disp_t2), 32'd0);
        check("rst_ret_en", 32'(bus.ret_en), 32'd0);
        check("d1_stall",   32'(bus.disp_stall), 32'd0);
        check("d1_t",       32'(bus.disp_t), 32'd32);
        check("d1_told",    32'(bus.disp_told), 32'd6);
        check("d1_idx",     32'(bus.disp_rob_idx), 32'd0);

        // addi r7 <- r7 + 5
        next_cycle();
        drive(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 6'd0, 1'b0, 5'd0);
        check("d2_t",      32'(bus.disp_t), 32'd33);
        check("d2_told",   32'(bus.disp_told), 32'd7);
        check("d2_idx",    32'(bus.disp_rob_idx), 32'd1);
        check("d2_t1_rdy", 32'(bus.disp_t1_rdy), 32'd1);

        // mult r15 <- r6 * r7 while the CDB broadcasts tag 33
        next_cycle();
        drive(1'b1, 1'b1, 5'd15, 5'd6, 5'd7, 1'b1, 6'd33, 1'b0, 5'd0);
        check("d3_t1",     32'(bus.disp_t1), 32'd32);
        check("d3_t1_rdy", 32'(bus.disp_t1_rdy), 32'd0);
        check("d3_t2",     32'(bus.disp_t2), 32'd33);
        check("d3_t2_fwd", 32'(bus.disp_t2_rdy), 32'd1);
        check("d3_t",      32'(bus.disp_t), 32'd34);
        check("d3_told",   32'(bus.disp_told), 32'd15);
        check("d3_idx",    32'(bus.disp_rob_idx), 32'd2);

        // CDB tag 32 and completion of slot 0; nothing retires yet
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 6'd32, 1'b1, 5'd0);
        check("c0_ret_en", 32'(bus.ret_en), 32'd0);

        // Slot 0 retires while r8 <- r6 + r7 dispatches
        next_cycle();
        drive(1'b1, 1'b1, 5'd8, 5'd6, 5'd7, 1'b0, 6'd0, 1'b0, 5'd0);
        check("r0_ret_en",   32'(bus.ret_en), 32'd1);
        check("r0_ret_dest", 32'(bus.ret_dest), 32'd6);
        check("r0_ret_t",    32'(bus.ret_t), 32'd32);
        check("r0_ret_told", 32'(bus.ret_told), 32'd6);
        check("d4_t1",       32'(bus.disp_t1), 32'd32);
        check("d4_t1_rdy",   32'(bus.disp_t1_rdy), 32'd1);
        check("d4_t2_rdy",   32'(bus.disp_t2_rdy), 32'd1);
        check("d4_t",        32'(bus.disp_t), 32'd35);
        check("d4_idx",      32'(bus.disp_rob_idx), 32'd3);

        // Drain the rest of the initial free tags with no retirement
        for (int k = 0; k < 28; k++) begin
            next_cycle();
            drive(1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd0);
            check("fill_stall", 32'(bus.disp_stall), 32'd0);
            check("fill_t",     32'(bus.disp_t), 32'(36 + k));
            check("fill_idx",   32'(bus.disp_rob_idx), 32'(4 + k));
        end

        // The recycled tag 6 follows 63; ROB index wraps to 0
        next_cycle();
        drive(1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd0);
        check("wrap_t",     32'(bus.disp_t), 32'd6);
        check("wrap_idx",   32'(bus.disp_rob_idx), 32'd0);
        check("wrap_stall", 32'(bus.disp_stall), 32'd0);

        // ROB full: stall, complete head slot 1
        next_cycle();
        drive(1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 6'd0, 1'b1, 5'd1);
        check("full_stall",  32'(bus.disp_stall), 32'd1);
        check("full_ret_en", 32'(bus.ret_en), 32'd0);

        // Retire frees a slot, but the stall holds this cycle
        next_cycle();
        drive(1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd0);
        check("r1_ret_en",   32'(bus.ret_en), 32'd1);
        check("r1_ret_dest", 32'(bus.ret_dest), 32'd7);
        check("r1_ret_told", 32'(bus.ret_told), 32'd7);
        check("r1_stall",    32'(bus.disp_stall), 32'd1);

        // Dispatch resumes with the freed tag 7
        next_cycle();
        drive(1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd0);
        check("res_stall", 32'(bus.disp_stall), 32'd0);
        check("res_t",     32'(bus.disp_t), 32'd7);
        check("res_told",  32'(bus.disp_told), 32'd10);
        check("res_idx",   32'(bus.disp_rob_idx), 32'd1);

        // Reset with a full ROB in flight: state is identity immediately
        next_cycle();
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd6, 5'd6, 5'd15, 1'b0, 6'd0, 1'b0, 5'd0);
        check("mr_t1",     32'(bus.disp_t1), 32'd6);
        check("mr_t1_rdy", 32'(bus.disp_t1_rdy), 32'd1);
        check("mr_t2",     32'(bus.disp_t2), 32'd15);
        check("mr_t",      32'(bus.disp_t), 32'd32);
        check("mr_told",   32'(bus.disp_told), 32'd6);
        check("mr_idx",    32'(bus.disp_rob_idx), 32'd0);
        check("mr_ret_en", 32'(bus.ret_en), 32'd0);
        check("mr_stall",  32'(bus.disp_stall), 32'd0);

        // Dest r0 takes no tag; completion of an empty slot is ignored
        next_cycle();
        reset = 1'b0;
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b1, 5'd0);
        check("r0d_t",    32'(bus.disp_t), 32'd0);
        check("r0d_told", 32'(bus.disp_told), 32'd0);
        check("r0d_idx",  32'(bus.disp_rob_idx), 32'd0);

        next_cycle();
        drive(1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 6'd0, 1'b0, 5'd0);
        check("post_t",      32'(bus.disp_t), 32'd32);
        check("post_idx",    32'(bus.disp_rob_idx), 32'd1);
        check("empty_cmpl",  32'(bus.ret_en), 32'd0);

        // Completing slot 0 now retires the r0 entry with no Told
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b1, 5'd0);
        check("late_ret_en0", 32'(bus.ret_en), 32'd0);
        next_cycle();
        idle();
        check("late_ret_en1", 32'(bus.ret_en), 32'd1);
        check("late_ret_t",   32'(bus.ret_t), 32'd0);
        check("late_ret_told", 32'(bus.ret_told), 32'd0);

        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
